// File: rtl/fp_stage_pkg.sv
// Shared opcodes, packet layouts and ALU helpers for the function-processing stage.
// The FP_MUL_EN macro (see fp_stage.sv) selects whether MUL is a real multiply.
package fp_stage_pkg;

    localparam logic [5:0] OPC_ADD    = 6'd1;
    localparam logic [5:0] OPC_SUB    = 6'd2;
    localparam logic [5:0] OPC_MUL    = 6'd3;
    localparam logic [5:0] OPC_ADDC   = 6'd4;
    localparam logic [5:0] OPC_BZ     = 6'd5;
    localparam logic [5:0] OPC_ABSORB = 6'd63;

    typedef struct packed {
        logic [10:0] cg;
        logic [6:0]  dest;
        logic [3:0]  flags;
        logic [5:0]  opc;
        logic [1:0]  tag;
        logic [15:0] l;
        logic [15:0] r;
    } pkt_in_t;

    typedef struct packed {
        logic [10:0] cg;
        logic [6:0]  dest;
        logic [3:0]  flags;
        logic [13:0] pad;
        logic [15:0] res;
    } pkt_out_t;

    typedef struct packed {
        logic [10:0] cg;
        logic [6:0]  dest;
        logic [3:0]  flags;
    } hdr_t;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

    // MUL falls into the pass-through default; the multiplier overrides it.
    function automatic logic [15:0] alu(
        input logic [5:0]  opc,
        input logic [15:0] l,
        input logic [15:0] r,
        input logic [3:0]  flags
    );
        logic [15:0] res;
        res = l;
        case (opc)
            OPC_ADD:  res = l + r;
            OPC_SUB:  res = l - r;
            OPC_ADDC: res = l + {12'd0, flags};
            default:  res = l;
        endcase
        return res;
    endfunction

    function automatic logic [6:0] next_dest(
        input logic [5:0]  opc,
        input logic [6:0]  dest,
        input logic [15:0] r
    );
        return (opc == OPC_BZ && r != 16'd0) ? dest + 7'd1 : dest;
    endfunction

endpackage

// File: rtl/fp_stage_mul16.sv
// Iterative shift-add 16x16 multiplier, one multiplier bit per cycle.
// Only compiled when FP_MUL_EN is defined.
`ifdef FP_MUL_EN
module fp_mul16
    import fp_stage_pkg::*;
#(
    parameter int MUL_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        done,
    output logic [15:0] prod
);

    localparam int CW = $clog2(MUL_CYC);

    logic [15:0]   mcand;
    logic [15:0]   mplier;
    logic [15:0]   acc;
    logic [CW-1:0] cnt;
    logic          run;

    // prod is the accumulator after the current step, so the last
    // step's sum can be captured downstream on the completing edge.
    assign prod = acc + (mplier[0] ? mcand : 16'd0);
    assign done = run && (cnt == CW'(MUL_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            acc    <= prod;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) run <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/fp_stage.sv
// Function-processing stage: executes one op per packet into a one-entry output register.
// Define FP_MUL_EN to build the iterative multiplier and the MUL_BUSY state.
module fp_stage
    import fp_stage_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int MUL_CYC = 16
) (
    input  logic        CP,
    input  logic        MR,
    input  logic        Send_in,
    output logic        Ack_out,
    input  logic [61:0] PACKET_IN,
    input  logic        DEL_in,
    output logic        Send_out,
    input  logic        Ack_in,
    output logic [51:0] PACKET_OUT,
    output logic        BUSY
);

    pkt_in_t           pin;
    pkt_out_t          alu_pkt;
    pkt_out_t          load_pkt;
    logic [DATA_W-1:0] res;
    logic              take;
    logic              idle;
    logic              load;
    logic              unused_bits;

    assign pin         = pkt_in_t'(PACKET_IN);
    assign res         = alu(pin.opc, pin.l, pin.r, pin.flags);
    assign take        = Send_in & Ack_out & DEL_in;
    assign unused_bits = ^{pin.tag, 32'(MUL_CYC)};

    assign alu_pkt = '{
        cg:    pin.cg,
        dest:  next_dest(pin.opc, pin.dest, pin.r),
        flags: pin.flags,
        pad:   '0,
        res:   res
    };

`ifdef FP_MUL_EN
    state_t      state;
    state_t      state_next;
    hdr_t        hdr;
    logic        is_mul;
    logic        mul_start;
    logic        mul_done;
    logic [15:0] mul_prod;

    assign is_mul    = (pin.opc == OPC_MUL);
    assign mul_start = take & is_mul;

    always_ff @(posedge CP or posedge MR) begin
        if (MR) state <= ST_IDLE;
        else    state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (mul_start) state_next = ST_MUL;
            ST_MUL:  if (mul_done)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The header rides alongside the multiply until the product is ready.
    always_ff @(posedge CP or posedge MR) begin
        if (MR)             hdr <= '0;
        else if (mul_start) hdr <= '{cg: pin.cg, dest: pin.dest, flags: pin.flags};
    end

    fp_mul16 #(
        .MUL_CYC(MUL_CYC)
    ) u_mul (
        .clk  (CP),
        .rst  (MR),
        .start(mul_start),
        .a    (pin.l),
        .b    (pin.r),
        .done (mul_done),
        .prod (mul_prod)
    );

    assign idle     = (state == ST_IDLE);
    assign BUSY     = (state == ST_MUL);
    assign load     = (take & ~is_mul) | mul_done;
    assign load_pkt = mul_done ? '{
        cg:    hdr.cg,
        dest:  hdr.dest,
        flags: hdr.flags,
        pad:   '0,
        res:   mul_prod
    } : alu_pkt;
`else
    assign idle     = 1'b1;
    assign BUSY     = 1'b0;
    assign load     = take;
    assign load_pkt = alu_pkt;
`endif

    assign Ack_out = ~MR & idle & (~Send_out | Ack_in);

    // A load wins over a same-edge consume, giving one packet per cycle.
    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            Send_out   <= 1'b0;
            PACKET_OUT <= '0;
        end else if (load) begin
            Send_out   <= 1'b1;
            PACKET_OUT <= load_pkt;
        end else if (Send_out & Ack_in) begin
            Send_out   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_stage.sv
// Self-checking bench for fp_stage: directed scenarios plus a randomized
// stream checked against an arithmetic reference model and a queue.
module tb_fp_stage;

    logic        CP = 1'b0;
    logic        MR = 1'b1;
    logic        Send_in = 1'b0;
    logic        Ack_out;
    logic [61:0] PACKET_IN = '0;
    logic        DEL_in = 1'b1;
    logic        Send_out;
    logic        Ack_in = 1'b1;
    logic [51:0] PACKET_OUT;
    logic        BUSY;

    int total = 0;
    int bad   = 0;

    fp_stage #(.DATA_W(16), .MUL_CYC(16)) dut (
        .CP        (CP),
        .MR        (MR),
        .Send_in   (Send_in),
        .Ack_out   (Ack_out),
        .PACKET_IN (PACKET_IN),
        .DEL_in    (DEL_in),
        .Send_out  (Send_out),
        .Ack_in    (Ack_in),
        .PACKET_OUT(PACKET_OUT),
        .BUSY      (BUSY)
    );

    always #5 CP = ~CP;

    function automatic logic [61:0] mk(input logic [10:0] cg, input logic [6:0] dest,
                                       input logic [3:0] fl, input logic [5:0] opc,
                                       input logic [15:0] l, input logic [15:0] r);
        return {cg, dest, fl, opc, 2'b00, l, r};
    endfunction

    function automatic logic [51:0] model(input logic [61:0] p);
        int unsigned cg, dest, fl, opc, l, r, res, nd;
        cg   = p[61:51];
        dest = p[50:44];
        fl   = p[43:40];
        opc  = p[39:34];
        l    = p[31:16];
        r    = p[15:0];
        case (opc)
            1:       res = (l + r) % 65536;
            2:       res = (l + 65536 - r) % 65536;
            4:       res = (l + fl) % 65536;
`ifdef FP_MUL_EN
            3:       res = (l * r) % 65536;
`endif
            default: res = l;
        endcase
        nd = (opc == 5 && r != 0) ? (dest + 1) % 128 : dest;
        return {cg[10:0], nd[6:0], fl[3:0], 14'd0, res[15:0]};
    endfunction

    task automatic step();
        @(posedge CP);
        @(negedge CP);
    endtask

    task automatic test_reset();
        @(negedge CP);
        total++; if (Send_out !== 1'b0) begin bad++; $display("FAIL reset_send_out got=%0b exp=0", Send_out); end
        total++; if (PACKET_OUT !== 52'd0) begin bad++; $display("FAIL reset_packet got=%h exp=0", PACKET_OUT); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", BUSY); end
        total++; if (Ack_out !== 1'b0) begin bad++; $display("FAIL reset_ack_out got=%0b exp=0", Ack_out); end
        MR = 1'b0;
        #1;
        total++; if (Ack_out !== 1'b1) begin bad++; $display("FAIL release_ack_out got=%0b exp=1", Ack_out); end
    endtask

    task automatic test_add();
        logic [61:0] p;
        p = mk(11'h155, 7'd9, 4'd0, 6'd1, 16'hFFFF, 16'h0002);
        Ack_in = 1'b0; Send_in = 1'b1; DEL_in = 1'b1; PACKET_IN = p;
        step();
        Send_in = 1'b0;
        #1;
        total++; if (Send_out !== 1'b1) begin bad++; $display("FAIL add_valid got=%0b exp=1", Send_out); end
        total++; if (PACKET_OUT !== model(p)) begin bad++; $display("FAIL add_pkt got=%h exp=%h", PACKET_OUT, model(p)); end
        total++; if (PACKET_OUT[15:0] !== 16'h0001 || PACKET_OUT[40:34] !== 7'd9 || PACKET_OUT[51:41] !== 11'h155)
            begin bad++; $display("FAIL add_fields got=%h exp res=0001 dest=9 cg=155", PACKET_OUT); end
        Ack_in = 1'b1;
        step();
        total++; if (Send_out !== 1'b0) begin bad++; $display("FAIL add_drain got=%0b exp=0", Send_out); end
    endtask

    task automatic test_back_to_back();
        logic [61:0] p1, p2;
        p1 = mk(11'h011, 7'd2, 4'd0, 6'd2, 16'd5, 16'd7);
        p2 = mk(11'h022, 7'd3, 4'hF, 6'd4, 16'd3, 16'd0);
        Ack_in = 1'b1; Send_in = 1'b1; PACKET_IN = p1;
        #1;
        total++; if (Ack_out !== 1'b1) begin bad++; $display("FAIL b2b_ack1 got=%0b exp=1", Ack_out); end
        step();
        PACKET_IN = p2;
        #1;
        total++; if (Send_out !== 1'b1 || PACKET_OUT[15:0] !== 16'hFFFE)
            begin bad++; $display("FAIL b2b_sub got=%0b/%h exp=1/fffe", Send_out, PACKET_OUT[15:0]); end
        total++; if (Ack_out !== 1'b1) begin bad++; $display("FAIL b2b_ack2 got=%0b exp=1", Ack_out); end
        step();
        Send_in = 1'b0;
        #1;
        total++; if (Send_out !== 1'b1 || PACKET_OUT !== model(p2) || PACKET_OUT[15:0] !== 16'h0012)
            begin bad++; $display("FAIL b2b_addc got=%h exp=%h", PACKET_OUT, model(p2)); end
        step();
        total++; if (Send_out !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0b exp=0", Send_out); end
    endtask

    task automatic test_bz();
        Ack_in = 1'b1; Send_in = 1'b1;
        PACKET_IN = mk(11'h7, 7'd4, 4'd0, 6'd5, 16'h1234, 16'd0);
        step();
        PACKET_IN = mk(11'h8, 7'd127, 4'd0, 6'd5, 16'h1234, 16'd1);
        #1;
        total++; if (PACKET_OUT[40:34] !== 7'd4 || PACKET_OUT[15:0] !== 16'h1234)
            begin bad++; $display("FAIL bz_zero got dest=%0d res=%h exp dest=4 res=1234", PACKET_OUT[40:34], PACKET_OUT[15:0]); end
        step();
        Send_in = 1'b0;
        #1;
        total++; if (PACKET_OUT[40:34] !== 7'd0 || PACKET_OUT[15:0] !== 16'h1234)
            begin bad++; $display("FAIL bz_wrap got dest=%0d res=%h exp dest=0 res=1234", PACKET_OUT[40:34], PACKET_OUT[15:0]); end
        step();
    endtask

    task automatic test_mul();
        logic [61:0] p;
        int low;
        p = mk(11'h3, 7'd1, 4'd0, 6'd3, 16'h0123, 16'h0100);
        Ack_in = 1'b1; Send_in = 1'b1; PACKET_IN = p;
        step();
        Send_in = 1'b0;
        #1;
`ifdef FP_MUL_EN
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL mul_busy got=%0b exp=1", BUSY); end
        low = 0;
        for (int i = 0; i < 40 && Send_out !== 1'b1; i++) begin
            if (Ack_out === 1'b0) low++;
            step();
            #1;
        end
        total++; if (low != 16) begin bad++; $display("FAIL mul_ack_low got=%0d exp=16", low); end
        total++; if (Send_out !== 1'b1 || PACKET_OUT[15:0] !== 16'h2300)
            begin bad++; $display("FAIL mul_result got=%0b/%h exp=1/2300", Send_out, PACKET_OUT[15:0]); end
`else
        low = 0;
        total++; if (Send_out !== 1'b1 || PACKET_OUT[15:0] !== 16'h0123)
            begin bad++; $display("FAIL mul_passthru got=%0b/%h exp=1/0123 low=%0d", Send_out, PACKET_OUT[15:0], low); end
`endif
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL mul_busy_end got=%0b exp=0", BUSY); end
        total++; if (PACKET_OUT !== model(p)) begin bad++; $display("FAIL mul_pkt got=%h exp=%h", PACKET_OUT, model(p)); end
        step();
    endtask

    task automatic test_del_hold();
        logic [61:0] p, q;
        Ack_in = 1'b1; Send_in = 1'b1; DEL_in = 1'b0;
        PACKET_IN = mk(11'h1, 7'd1, 4'd0, 6'd63, 16'hAAAA, 16'd0);
        step();
        DEL_in = 1'b1;
        PACKET_IN = mk(11'h2, 7'd2, 4'd0, 6'd1, 16'd1, 16'd1);
        #1;
        total++; if (Send_out !== 1'b0) begin bad++; $display("FAIL del_dropped got=%0b exp=0", Send_out); end
        step();
        Send_in = 1'b0;
        #1;
        total++; if (Send_out !== 1'b1 || PACKET_OUT[15:0] !== 16'h0002)
            begin bad++; $display("FAIL del_add got=%0b/%h exp=1/0002", Send_out, PACKET_OUT[15:0]); end
        step();
        total++; if (Send_out !== 1'b0) begin bad++; $display("FAIL del_single got=%0b exp=0", Send_out); end
        p = mk(11'h4, 7'd5, 4'd2, 6'd1, 16'd7, 16'd8);
        q = mk(11'h5, 7'd6, 4'd1, 6'd2, 16'd100, 16'd1);
        Ack_in = 1'b0; Send_in = 1'b1; PACKET_IN = p;
        step();
        PACKET_IN = q;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (Send_out !== 1'b1 || PACKET_OUT !== model(p) || Ack_out !== 1'b0)
                begin bad++; $display("FAIL hold_%0d got=%0b/%h/%0b exp=1/%h/0", i, Send_out, PACKET_OUT, Ack_out, model(p)); end
            step();
        end
        Ack_in = 1'b1;
        #1;
        total++; if (Ack_out !== 1'b1) begin bad++; $display("FAIL hold_release got=%0b exp=1", Ack_out); end
        step();
        Send_in = 1'b0;
        #1;
        total++; if (Send_out !== 1'b1 || PACKET_OUT !== model(q))
            begin bad++; $display("FAIL hold_reload got=%h exp=%h", PACKET_OUT, model(q)); end
        step();
    endtask

    task automatic test_reset_mid_mul();
        logic [61:0] p;
        Ack_in = 1'b0; Send_in = 1'b1;
        PACKET_IN = mk(11'h9, 7'd9, 4'd0, 6'd3, 16'h00FF, 16'h0003);
        step();
        Send_in = 1'b0;
        repeat (8) step();
        MR = 1'b1;
        #1;
        total++; if (Send_out !== 1'b0 || BUSY !== 1'b0 || Ack_out !== 1'b0)
            begin bad++; $display("FAIL midreset got=%0b/%0b/%0b exp=0/0/0", Send_out, BUSY, Ack_out); end
        step();
        MR = 1'b0; Ack_in = 1'b1;
        p = mk(11'h10, 7'd11, 4'd0, 6'd1, 16'h0010, 16'h0020);
        Send_in = 1'b1; PACKET_IN = p;
        step();
        Send_in = 1'b0;
        #1;
        total++; if (Send_out !== 1'b1 || PACKET_OUT !== model(p))
            begin bad++; $display("FAIL after_reset got=%0b/%h exp=1/%h", Send_out, PACKET_OUT, model(p)); end
        step();
    endtask

    task automatic test_random();
        logic [51:0] exp_q[$];
        logic [63:0] w;
        logic [61:0] p;
        logic [5:0]  ops[6];
        ops = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd63};
        for (int c = 0; c < 400; c++) begin
            Ack_in  = ($urandom_range(0, 3) != 0);
            Send_in = $urandom_range(0, 1) == 1;
            DEL_in  = ($urandom_range(0, 4) != 0);
            w = {$urandom(), $urandom()};
            p = w[61:0];
            p[39:34] = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 1) == 1) p[15:0] = 16'd0;
            PACKET_IN = p;
            #1;
            if (Send_out && Ack_in) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rnd_spurious got=%h exp=none", PACKET_OUT);
                end else begin
                    if (PACKET_OUT !== exp_q[0]) begin bad++; $display("FAIL rnd_pkt got=%h exp=%h", PACKET_OUT, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
            end
            if (Send_in && Ack_out && DEL_in) exp_q.push_back(model(p));
            step();
        end
        Send_in = 1'b0; Ack_in = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            #1;
            if (Send_out) begin
                total++;
                if (PACKET_OUT !== exp_q[0]) begin bad++; $display("FAIL rnd_drain got=%h exp=%h", PACKET_OUT, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            step();
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_left got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_bz();
        test_mul();
        test_del_hold();
        test_reset_mid_mul();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
